// File: rtl/ioctl_load_pkg.sv
// rtl/ioctl_load_pkg.sv - loader state type and ioctl index constants
package ioctl_load_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROM  = 3'd1,
    WAIT = 3'd2,
    DIP  = 3'd3,
    HOLD = 3'd4
  } state_e;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/reset_stretch.sv
// rtl/reset_stretch.sv - post-load hold counter and registered core reset
module reset_stretch #(
  parameter int RESET_HOLD = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic user_rst,
  input  logic busy,
  input  logic hold_active,
  output logic hold_done,
  output logic core_reset
);

  localparam int CW = $clog2(RESET_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          core_reset_q, core_reset_d;

  // The counter idles at RESET_HOLD so HOLD always starts from a full count.
  always_comb begin
    cnt_d        = CW'(RESET_HOLD);
    core_reset_d = user_rst | busy;
    if (hold_active) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign hold_done  = hold_active && (cnt_q == CW'(1));
  assign core_reset = core_reset_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= CW'(RESET_HOLD);
      core_reset_q <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

endmodule

// File: rtl/ioctl_load_ctrl.sv
// rtl/ioctl_load_ctrl.sv - routes the hps ioctl download into ROM loader and DIP bank
// Optional LOAD_CHECKSUM_EN adds rom_sum, the 16-bit sum of accepted ROM bytes.
module ioctl_load_ctrl
  import ioctl_load_pkg::*;
#(
  parameter int          ROM_BYTES   = 65536,
  parameter int          DL_AW       = 17,
  parameter int          RESET_HOLD  = 256,
  parameter logic [63:0] DIP_DEFAULT = 64'h0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             user_rst,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic             ioctl_wait,
  output logic [DL_AW-1:0] dl_addr,
  output logic [7:0]       dl_data,
  output logic             dl_wr,
  input  logic             dl_ack,
  output logic [63:0]      dip_sw,
  output logic             core_reset,
  output logic             rom_loaded,
  output logic             dl_overflow,
  output logic [DL_AW:0]   byte_count
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [15:0]      rom_sum
`endif
);

  state_e           state_q, state_d;
  logic             dl_wr_q, dl_wr_d;
  logic [DL_AW-1:0] dl_addr_q, dl_addr_d;
  logic [7:0]       dl_data_q, dl_data_d;
  logic [63:0]      dip_sw_q, dip_sw_d;
  logic             rom_loaded_q, rom_loaded_d;
  logic             dl_overflow_q, dl_overflow_d;
  logic [DL_AW:0]   byte_count_q, byte_count_d;
  logic             skip_q, skip_d;
  logic             hold_done;
  logic             busy;
  logic             addr_in_range;
`ifdef LOAD_CHECKSUM_EN
  logic [15:0]      rom_sum_q, rom_sum_d;
`endif

  assign addr_in_range = ioctl_addr < 25'(ROM_BYTES);
  assign busy          = (state_q == ROM) || (state_q == WAIT) || (state_q == HOLD);

  always_comb begin
    state_d       = state_q;
    dl_wr_d       = dl_wr_q;
    dl_addr_d     = dl_addr_q;
    dl_data_d     = dl_data_q;
    dip_sw_d      = dip_sw_q;
    rom_loaded_d  = rom_loaded_q;
    dl_overflow_d = dl_overflow_q;
    byte_count_d  = byte_count_q;
    skip_d        = skip_q;
`ifdef LOAD_CHECKSUM_EN
    rom_sum_d     = rom_sum_q;
`endif
    case (state_q)
      IDLE: begin
        // A download of any other index is sat out until it ends, even if the index changes.
        if (!ioctl_download) begin
          skip_d = 1'b0;
        end else if (!skip_q) begin
          if (ioctl_index == IDX_ROM) begin
            state_d      = ROM;
            byte_count_d = '0;
`ifdef LOAD_CHECKSUM_EN
            rom_sum_d    = 16'd0;
`endif
          end else if (ioctl_index == IDX_DIP) begin
            state_d = DIP;
          end else begin
            skip_d = 1'b1;
          end
        end
      end
      ROM: begin
        if (!ioctl_download) begin
          state_d = HOLD;
        end else if (ioctl_wr) begin
          if (addr_in_range) begin
            dl_addr_d = ioctl_addr[DL_AW-1:0];
            dl_data_d = ioctl_dout;
            dl_wr_d   = 1'b1;
            state_d   = WAIT;
          end else begin
            dl_overflow_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (ioctl_wr) begin
          dl_overflow_d = 1'b1;
        end
        if (dl_ack) begin
          dl_wr_d      = 1'b0;
          byte_count_d = byte_count_q + (DL_AW + 1)'(1);
`ifdef LOAD_CHECKSUM_EN
          rom_sum_d    = rom_sum_q + 16'(dl_data_q);
`endif
          state_d      = ioctl_download ? ROM : HOLD;
        end
      end
      DIP: begin
        if (!ioctl_download) begin
          state_d = IDLE;
        end else if (ioctl_wr && (ioctl_addr[24:3] == 22'd0)) begin
          dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
      end
      HOLD: begin
        rom_loaded_d = 1'b1;
        if (hold_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      dl_wr_q       <= 1'b0;
      dl_addr_q     <= '0;
      dl_data_q     <= 8'd0;
      dip_sw_q      <= DIP_DEFAULT;
      rom_loaded_q  <= 1'b0;
      dl_overflow_q <= 1'b0;
      byte_count_q  <= '0;
      skip_q        <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      rom_sum_q     <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      dl_wr_q       <= dl_wr_d;
      dl_addr_q     <= dl_addr_d;
      dl_data_q     <= dl_data_d;
      dip_sw_q      <= dip_sw_d;
      rom_loaded_q  <= rom_loaded_d;
      dl_overflow_q <= dl_overflow_d;
      byte_count_q  <= byte_count_d;
      skip_q        <= skip_d;
`ifdef LOAD_CHECKSUM_EN
      rom_sum_q     <= rom_sum_d;
`endif
    end
  end

  reset_stretch #(
    .RESET_HOLD(RESET_HOLD)
  ) u_reset_stretch (
    .clk        (clk_sys),
    .reset      (reset),
    .user_rst   (user_rst),
    .busy       (busy),
    .hold_active(state_q == HOLD),
    .hold_done  (hold_done),
    .core_reset (core_reset)
  );

  // hps_io must stall for exactly as long as a ROM write is outstanding.
  assign ioctl_wait  = dl_wr_q;
  assign dl_wr       = dl_wr_q;
  assign dl_addr     = dl_addr_q;
  assign dl_data     = dl_data_q;
  assign dip_sw      = dip_sw_q;
  assign rom_loaded  = rom_loaded_q;
  assign dl_overflow = dl_overflow_q;
  assign byte_count  = byte_count_q;
`ifdef LOAD_CHECKSUM_EN
  assign rom_sum     = rom_sum_q;
`endif

endmodule

// File: tb/tb_ioctl_load_ctrl.sv
// tb/tb_ioctl_load_ctrl.sv - directed plus randomized bench for ioctl_load_ctrl
module tb_ioctl_load_ctrl;

  localparam int          ROM_BYTES   = 65536;
  localparam int          DL_AW       = 17;
  localparam int          RESET_HOLD  = 256;
  localparam logic [63:0] DIP_DEFAULT = 64'hA5A5_0000_0000_5A5A;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             user_rst;
  logic             ioctl_download;
  logic [7:0]       ioctl_index;
  logic             ioctl_wr;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic             ioctl_wait;
  logic [DL_AW-1:0] dl_addr;
  logic [7:0]       dl_data;
  logic             dl_wr;
  logic             dl_ack;
  logic [63:0]      dip_sw;
  logic             core_reset;
  logic             rom_loaded;
  logic             dl_overflow;
  logic [DL_AW:0]   byte_count;
`ifdef LOAD_CHECKSUM_EN
  logic [15:0]      rom_sum;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_count;
  logic        exp_ovf;
  logic [63:0] exp_dip;
  logic [15:0] exp_sum;

  always #5 clk_sys = ~clk_sys;

  ioctl_load_ctrl #(
    .ROM_BYTES  (ROM_BYTES),
    .DL_AW      (DL_AW),
    .RESET_HOLD (RESET_HOLD),
    .DIP_DEFAULT(DIP_DEFAULT)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .user_rst      (user_rst),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .dl_wr         (dl_wr),
    .dl_ack        (dl_ack),
    .dip_sw        (dip_sw),
    .core_reset    (core_reset),
    .rom_loaded    (rom_loaded),
    .dl_overflow   (dl_overflow),
    .byte_count    (byte_count)
`ifdef LOAD_CHECKSUM_EN
    , .rom_sum     (rom_sum)
`endif
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_rom();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    tick();
    exp_count = 0;
    exp_sum   = 16'd0;
    chk("rom_entry_core_reset", core_reset, 1);
    chk("rom_entry_count", byte_count, 0);
  endtask

  task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input int dly, input bit inject);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (a < 25'(ROM_BYTES)) begin
      chk("wr_req", dl_wr, 1);
      chk("wait_req", ioctl_wait, 1);
      chk("wr_addr", dl_addr, a);
      chk("wr_data", dl_data, d);
      for (int i = 0; i < dly; i++) begin
        if (inject && i == 0) begin
          ioctl_addr = a ^ 25'h1;
          ioctl_dout = ~d;
          ioctl_wr   = 1'b1;
          exp_ovf    = 1'b1;
        end
        tick();
        ioctl_wr = 1'b0;
        chk("wr_held", dl_wr, 1);
        chk("wait_held", ioctl_wait, 1);
        chk("addr_held", dl_addr, a);
        chk("data_held", dl_data, d);
      end
      dl_ack = 1'b1;
      tick();
      dl_ack    = 1'b0;
      exp_count = exp_count + 1;
      exp_sum   = exp_sum + 16'(d);
      chk("wr_done", dl_wr, 0);
      chk("wait_done", ioctl_wait, 0);
    end else begin
      exp_ovf = 1'b1;
      chk("wr_dropped", dl_wr, 0);
    end
    chk("byte_count", byte_count, exp_count);
    chk("overflow", dl_overflow, exp_ovf);
`ifdef LOAD_CHECKSUM_EN
    chk("rom_sum", rom_sum, exp_sum);
`endif
  endtask

  // Inputs for the final edge (download low and/or ack) are already driven by the caller.
  task automatic measure_release();
    int n;
    tick();
    dl_ack = 1'b0;
    chk("rel_core_reset_hi", core_reset, 1);
    n = 0;
    while (core_reset !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("release_delay", n, RESET_HOLD + 1);
    chk("rom_loaded", rom_loaded, 1);
  endtask

  initial begin
    logic [24:0] a;
    logic [7:0]  d;
    int          r;

    reset          = 1'b1;
    user_rst       = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    dl_ack         = 1'b0;
    exp_ovf        = 1'b0;
    exp_dip        = DIP_DEFAULT;
    exp_count      = 0;
    exp_sum        = 16'd0;

    tick();
    tick();
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_dl_wr", dl_wr, 0);
    chk("rst_dl_addr", dl_addr, 0);
    chk("rst_dl_data", dl_data, 0);
    chk("rst_dip", dip_sw, exp_dip);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_loaded", rom_loaded, 0);
    chk("rst_ovf", dl_overflow, 0);
    chk("rst_count", byte_count, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_core_reset", core_reset, 0);

    user_rst = 1'b1;
    tick();
    chk("user_rst_hi", core_reset, 1);
    user_rst = 1'b0;
    tick();
    chk("user_rst_lo", core_reset, 0);

    // Four-byte load, ack two cycles after each request.
    start_rom();
    for (int i = 0; i < 4; i++) begin
      rom_byte(25'(i), 8'($urandom), 2, 1'b0);
    end
    chk("load1_count", byte_count, 4);
    chk("load1_not_loaded", rom_loaded, 0);
    ioctl_download = 1'b0;
    measure_release();

    // DIP bank download.
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    tick();
    tick();
    chk("dip_core_reset", core_reset, 0);
    ioctl_addr = 25'd1;
    ioctl_dout = 8'hC2;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr       = 1'b0;
    exp_dip[15:8]  = 8'hC2;
    chk("dip_c2", dip_sw, exp_dip);
    chk("dip_c2_core_reset", core_reset, 0);
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 3));
      a = (r == 0) ? 25'(8 + $urandom_range(0, 1000)) : 25'($urandom_range(0, 7));
      d = 8'($urandom);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      if (a < 25'd8) exp_dip[int'(a) * 8 +: 8] = d;
      chk("dip_rand", dip_sw, exp_dip);
      chk("dip_rand_core_reset", core_reset, 0);
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("dip_exit_core_reset", core_reset, 0);

    // A foreign-index download stays ignored even after the index switches to ROM.
    ioctl_index    = 8'd5;
    ioctl_download = 1'b1;
    tick();
    tick();
    ioctl_index = 8'd0;
    tick();
    tick();
    ioctl_addr = 25'd0;
    ioctl_dout = 8'h11;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("foreign_no_wr", dl_wr, 0);
    chk("foreign_core_reset", core_reset, 0);
    chk("foreign_count", byte_count, exp_count);
    ioctl_download = 1'b0;
    tick();
    tick();

    // Checksum pair, boundary addresses, random bytes, then download falls mid-WAIT.
    start_rom();
    rom_byte(25'h00010, 8'hFF, 1, 1'b0);
    rom_byte(25'h00011, 8'h02, 0, 1'b0);
`ifdef LOAD_CHECKSUM_EN
    chk("rom_sum_0101", rom_sum, 16'h0101);
`endif
    chk("ovf_still_clear", dl_overflow, 0);
    rom_byte(25'(ROM_BYTES - 1), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
    rom_byte(25'(ROM_BYTES), 8'($urandom), 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 3));
      a = (r == 0) ? 25'(ROM_BYTES + $urandom_range(0, 100000)) : 25'($urandom_range(0, ROM_BYTES - 1));
      rom_byte(a, 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
    ioctl_addr = 25'h123;
    ioctl_dout = 8'h3C;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("fall_wr_req", dl_wr, 1);
    ioctl_download = 1'b0;
    tick();
    chk("fall_wr_held", dl_wr, 1);
    chk("fall_core_reset", core_reset, 1);
    tick();
    chk("fall_wr_held2", dl_wr, 1);
    dl_ack    = 1'b1;
    exp_count = exp_count + 1;
    exp_sum   = exp_sum + 16'h003C;
    measure_release();
    chk("fall_count", byte_count, exp_count);
    chk("fall_wr_done", dl_wr, 0);
    chk("fall_ovf_sticky", dl_overflow, exp_ovf);
`ifdef LOAD_CHECKSUM_EN
    chk("fall_rom_sum", rom_sum, exp_sum);
`endif

    // Reset while a write is outstanding.
    start_rom();
    ioctl_addr = 25'd5;
    ioctl_dout = 8'h77;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("mid_wr_req", dl_wr, 1);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset     = 1'b0;
    exp_ovf   = 1'b0;
    exp_dip   = DIP_DEFAULT;
    exp_count = 0;
    chk("mid_rst_dl_wr", dl_wr, 0);
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_core_reset", core_reset, 1);
    chk("mid_rst_dip", dip_sw, exp_dip);
    chk("mid_rst_loaded", rom_loaded, 0);
    chk("mid_rst_ovf", dl_overflow, 0);
    chk("mid_rst_count", byte_count, 0);
    tick();
    chk("mid_rst_idle", core_reset, 0);

    // Write arriving during WAIT is dropped; the pending byte still completes.
    start_rom();
    rom_byte(25'($urandom_range(0, ROM_BYTES - 1)), 8'($urandom), 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rom_byte(25'($urandom_range(0, ROM_BYTES - 1)), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
    ioctl_download = 1'b0;
    measure_release();
    chk("inj_count", byte_count, exp_count);
    chk("inj_ovf", dl_overflow, 1);
`ifdef LOAD_CHECKSUM_EN
    chk("inj_rom_sum", rom_sum, exp_sum);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
